// File: rtl/conv_pool_pkg.sv
// Shared types, constants and arithmetic helpers for the conv/pool engine.
// Optional average pooling is enabled with CONV_POOL_AVG_EN.
package conv_pool_pkg;

    typedef enum logic [1:0] {IDLE, MAC, EMIT} conv_eng_state_t;

    localparam int NUM_TAPS = 9;
    localparam int NUM_WIN  = 4;
    // Window origin LUT indexed by window number: bit w gives row/col origin.
    localparam logic [NUM_WIN-1:0] WIN_ROW_LUT = 4'b1100;
    localparam logic [NUM_WIN-1:0] WIN_COL_LUT = 4'b1010;

    function automatic logic signed [31:0] tap_mac(input logic [15:0] pix,
                                                   input logic signed [15:0] tap);
        logic signed [31:0] pe;
        logic signed [31:0] te;
        pe = {16'd0, pix};
        te = {{16{tap[15]}}, tap};
        return pe * te;
    endfunction

    function automatic logic [15:0] sat_u(input logic signed [31:0] v, input int w);
        logic signed [31:0] mx;
        mx = (32'sd1 <<< w) - 32'sd1;
        if (v < 0)
            return '0;
        else if (v > mx)
            return mx[15:0];
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/conv_pool_engine_if.sv
// Handshake and data bundle between a tile source/result sink and the engine.
// pool_mode exists only when CONV_POOL_AVG_EN is defined.
interface conv_pool_engine_if #(
    parameter int NUM_CH  = 3,
    parameter int PIX_W   = 8,
    parameter int KW      = 8,
    parameter int SHIFT_W = 2,
    parameter int ADDR_W  = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [16*PIX_W-1:0]        image;
    logic [NUM_CH*9*KW-1:0]     kernels;
    logic [SHIFT_W-1:0]         shift;
    logic                       addr_clr;
    logic                       out_valid;
    logic                       out_ready;
    logic [ADDR_W-1:0]          out_addr;
    logic [NUM_CH*PIX_W-1:0]    y;
`ifdef CONV_POOL_AVG_EN
    logic                       pool_mode;
`endif

    modport master (
`ifdef CONV_POOL_AVG_EN
        output pool_mode,
`endif
        output in_valid, image, kernels, shift, addr_clr, out_ready,
        input  in_ready, out_valid, out_addr, y
    );

    modport slave (
`ifdef CONV_POOL_AVG_EN
        input  pool_mode,
`endif
        input  in_valid, image, kernels, shift, addr_clr, out_ready,
        output in_ready, out_valid, out_addr, y
    );
endinterface

// File: rtl/conv_pool_reduce.sv
// Per-channel shift, unsigned saturation and 2x2 pooling of four window sums.
// Average pooling (round-half-up) is selectable when CONV_POOL_AVG_EN is defined.
module conv_pool_reduce
    import conv_pool_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int ACC_W   = 22,
    parameter int FRAC    = 3,
    parameter int SHIFT_W = 2
) (
    input  logic [NUM_WIN*ACC_W-1:0] acc,
    input  logic [SHIFT_W-1:0]       shift,
`ifdef CONV_POOL_AVG_EN
    input  logic                     pool_mode,
`endif
    output logic [PIX_W-1:0]         y
);
    logic [PIX_W-1:0] s [NUM_WIN];
    logic [PIX_W-1:0] mx;
`ifdef CONV_POOL_AVG_EN
    localparam int SUM_W = PIX_W + 3;
    logic [SUM_W-1:0] sum;
`endif

    for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
        logic signed [ACC_W-1:0] a;
        assign a    = acc[w*ACC_W +: ACC_W];
        assign s[w] = PIX_W'(sat_u(32'(a >>> (FRAC + int'(shift))), PIX_W));
    end

    always_comb begin
        mx = s[0];
        for (int w = 1; w < NUM_WIN; w++)
            if (s[w] > mx) mx = s[w];
        y = mx;
`ifdef CONV_POOL_AVG_EN
        sum = '0;
        for (int w = 0; w < NUM_WIN; w++)
            sum = sum + SUM_W'(s[w]);
        if (pool_mode) y = PIX_W'((sum + SUM_W'(2)) >> 2);
`endif
    end
endmodule

// File: rtl/conv_pool_engine.sv
// 3x3 conv over four windows of a 4x4 tile, NUM_CH kernels in parallel, then 2x2 pooling.
// Define CONV_POOL_AVG_EN to add the pool_mode (max/average) selection.
module conv_pool_engine
    import conv_pool_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int PIX_W   = 8,
    parameter int KW      = 8,
    parameter int FRAC    = 3,
    parameter int ACC_W   = 22,
    parameter int SHIFT_W = 2,
    parameter int ADDR_W  = 16
) (
    input logic               clk,
    input logic               rst,
    conv_pool_engine_if.slave bus
);
    conv_eng_state_t state_q, state_d;
    logic [16*PIX_W-1:0]           image_q;
    logic [NUM_CH*NUM_TAPS*KW-1:0] kern_q;
    logic [SHIFT_W-1:0]            shift_q;
`ifdef CONV_POOL_AVG_EN
    logic                          pool_q;
`endif
    logic [1:0] ky_q, kx_q, w_q, pix_r, pix_c;
    logic [PIX_W-1:0] pix;
    logic signed [ACC_W-1:0] acc_q [NUM_CH][NUM_WIN];
    logic signed [ACC_W-1:0] acc_d [NUM_CH][NUM_WIN];
    logic [NUM_CH*PIX_W-1:0] y_q, y_d;
    logic [ADDR_W-1:0] addr_q;
    logic accept, last_tap, emit_hs, in_ready, out_valid;

    assign accept   = (state_q == IDLE) && bus.in_valid;
    assign emit_hs  = (state_q == EMIT) && bus.out_ready;
    assign last_tap = (state_q == MAC) && (w_q == 2'd3) && (ky_q == 2'd2) && (kx_q == 2'd2);
    assign pix_r    = 2'(WIN_ROW_LUT[w_q]) + ky_q;
    assign pix_c    = 2'(WIN_COL_LUT[w_q]) + kx_q;
    assign pix      = image_q[int'({pix_r, pix_c})*PIX_W +: PIX_W];

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_d = MAC;
            end
            MAC:  if (last_tap) state_d = EMIT;
            EMIT: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The reducers see acc_d so the final tap is included when y registers on MAC->EMIT.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++)
            for (int w = 0; w < NUM_WIN; w++)
                acc_d[k][w] = acc_q[k][w];
        if (state_q == MAC)
            for (int k = 0; k < NUM_CH; k++)
                acc_d[k][w_q] = acc_q[k][w_q] + ACC_W'(tap_mac(16'(pix),
                    16'(signed'(kern_q[(k*NUM_TAPS + int'(ky_q)*3 + int'(kx_q))*KW +: KW]))));
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [NUM_WIN*ACC_W-1:0] acc_flat;
        logic [PIX_W-1:0]         y_ch;
        for (genvar w = 0; w < NUM_WIN; w++) begin : g_flat
            assign acc_flat[w*ACC_W +: ACC_W] = acc_d[k][w];
        end
        conv_pool_reduce #(.PIX_W(PIX_W), .ACC_W(ACC_W), .FRAC(FRAC), .SHIFT_W(SHIFT_W)) u_reduce (
            .acc       (acc_flat),
            .shift     (shift_q),
`ifdef CONV_POOL_AVG_EN
            .pool_mode (pool_q),
`endif
            .y         (y_ch)
        );
        assign y_d[k*PIX_W +: PIX_W] = y_ch;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            image_q <= bus.image;
            kern_q  <= bus.kernels;
            shift_q <= bus.shift;
`ifdef CONV_POOL_AVG_EN
            pool_q  <= bus.pool_mode;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ky_q    <= '0;
            kx_q    <= '0;
            w_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            for (int k = 0; k < NUM_CH; k++)
                for (int w = 0; w < NUM_WIN; w++)
                    acc_q[k][w] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ky_q <= '0;
                kx_q <= '0;
                w_q  <= '0;
                for (int k = 0; k < NUM_CH; k++)
                    for (int w = 0; w < NUM_WIN; w++)
                        acc_q[k][w] <= '0;
            end else if (state_q == MAC) begin
                acc_q <= acc_d;
                if (kx_q == 2'd2) begin
                    kx_q <= '0;
                    if (ky_q == 2'd2) begin
                        ky_q <= '0;
                        w_q  <= w_q + 2'd1;
                    end else begin
                        ky_q <= ky_q + 2'd1;
                    end
                end else begin
                    kx_q <= kx_q + 2'd1;
                end
            end
            if (last_tap) y_q <= y_d;
            if (bus.addr_clr)  addr_q <= '0;
            else if (emit_hs)  addr_q <= addr_q + ADDR_W'(1);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_addr  = addr_q;
    assign bus.y         = y_q;
endmodule

// File: tb/tb_conv_pool_engine.sv
// Directed bench for conv_pool_engine (ADDR_W=4); average-pool cases run when CONV_POOL_AVG_EN is defined.
`timescale 1ns/1ps
module tb_conv_pool_engine;
    localparam int NUM_CH = 3, PIX_W = 8, KW = 8, SHIFT_W = 2, ADDR_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [16*PIX_W-1:0]    img;
    logic [NUM_CH*9*KW-1:0] kern;

    conv_pool_engine_if #(.NUM_CH(NUM_CH), .PIX_W(PIX_W), .KW(KW), .SHIFT_W(SHIFT_W), .ADDR_W(ADDR_W)) bus ();

    conv_pool_engine #(.NUM_CH(NUM_CH), .PIX_W(PIX_W), .KW(KW), .FRAC(3), .ACC_W(22),
                       .SHIFT_W(SHIFT_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic ramp_image();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img[(r*4+c)*8 +: 8] = 8'(4*r + c + 1);
    endtask

    task automatic set_tap(input int k, input int t, input logic [7:0] v);
        kern[(k*9+t)*8 +: 8] = v;
    endtask

    task automatic identity_kernels();
        kern = '0;
        for (int k = 0; k < NUM_CH; k++) set_tap(k, 4, 8'h08);
    endtask

    task automatic start_tile();
        @(negedge clk);
        bus.image    = img;
        bus.kernels  = kern;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.out_valid !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.y !== 24'h0) begin failures++; $display("FAIL reset_y got=%h exp=000000", bus.y); end
        checks++; if (bus.out_addr !== 4'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bus.out_addr); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_identity();
        int n;
        bus.shift = 2'd0; bus.out_ready = 1'b1;
        ramp_image(); identity_kernels();
        start_tile();
        wait_valid(n);
        // n counts edges after the acceptance edge: the 37th edge counting acceptance itself
        checks++; if (n != 36) begin failures++; $display("FAIL identity_latency got=%0d exp=36", n); end
        checks++; if (bus.y !== 24'h0B0B0B) begin failures++; $display("FAIL identity_y got=%h exp=0b0b0b", bus.y); end
        checks++; if (bus.out_addr !== 4'd0) begin failures++; $display("FAIL identity_addr got=%0d exp=0", bus.out_addr); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++;
            $display("FAIL identity_release got valid=%b ready=%b exp valid=0 ready=1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_taps();
        int n;
        ramp_image(); kern = '0;
        set_tap(0, 0, 8'h08); set_tap(1, 8, 8'h08); set_tap(2, 2, 8'h08);
        start_tile();
        wait_valid(n);
        checks++; if (bus.y !== {8'd8, 8'd16, 8'd6}) begin failures++; $display("FAIL taps_y got=%h exp=081006", bus.y); end
        checks++; if (bus.out_addr !== 4'd1) begin failures++; $display("FAIL taps_addr got=%0d exp=1", bus.out_addr); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int n;
        img = '1;
        kern = '0; for (int i = 0; i < NUM_CH*9; i++) kern[i*8 +: 8] = 8'h7F;
        start_tile(); wait_valid(n);
        checks++; if (bus.y !== 24'hFFFFFF) begin failures++; $display("FAIL sat_high_y got=%h exp=ffffff", bus.y); end
        @(negedge clk);
        for (int i = 0; i < NUM_CH*9; i++) kern[i*8 +: 8] = 8'h80;
        start_tile(); wait_valid(n);
        checks++; if (bus.y !== 24'h000000) begin failures++; $display("FAIL sat_low_y got=%h exp=000000", bus.y); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        ramp_image(); kern = '0;
        set_tap(0, 4, 8'h08); set_tap(1, 4, 8'hF8); set_tap(2, 4, 8'h10);
        bus.shift = 2'd1; bus.out_ready = 1'b0;
        start_tile(); wait_valid(n);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid !== 1'b1 || bus.y !== {8'd11, 8'd0, 8'd5} || bus.out_addr !== 4'd4 || bus.in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin failures++;
            $display("FAIL bp_hold got valid=%b y=%h addr=%0d ready=%b exp valid=1 y=0b0005 addr=4 ready=0",
                     bus.out_valid, bus.y, bus.out_addr, bus.in_ready); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_addr !== 4'd5 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++;
            $display("FAIL bp_release got addr=%0d ready=%b valid=%b exp addr=5 ready=1 valid=0", bus.out_addr, bus.in_ready, bus.out_valid); end
        bus.shift = 2'd0;
    endtask

    task automatic test_async_reset();
        int n;
        int seen;
        ramp_image(); identity_kernels();
        start_tile();
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_addr !== 4'd0) begin failures++;
            $display("FAIL areset_now got ready=%b valid=%b addr=%0d exp ready=1 valid=0 addr=0", bus.in_ready, bus.out_valid, bus.out_addr); end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (50) begin @(negedge clk); if (bus.out_valid !== 1'b0) seen++; end
        checks++; if (seen != 0 || bus.in_ready !== 1'b1) begin failures++;
            $display("FAIL areset_spurious got valid_cycles=%0d ready=%b exp valid_cycles=0 ready=1", seen, bus.in_ready); end
        start_tile(); wait_valid(n);
        checks++; if (bus.y !== 24'h0B0B0B || bus.out_addr !== 4'd0) begin failures++;
            $display("FAIL areset_next got y=%h addr=%0d exp y=0b0b0b addr=0", bus.y, bus.out_addr); end
        @(negedge clk);
    endtask

    task automatic test_address();
        int n;
        ramp_image(); identity_kernels();
        @(negedge clk); bus.addr_clr = 1'b1;
        @(negedge clk); bus.addr_clr = 1'b0;
        checks++; if (bus.out_addr !== 4'd0) begin failures++; $display("FAIL addr_clr_idle got=%0d exp=0", bus.out_addr); end
        bus.image = img; bus.kernels = kern; bus.in_valid = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            wait_valid(n);
            if (i > 0) begin
                checks++; if (n != 37) begin failures++; $display("FAIL b2b_interval tile=%0d got=%0d exp=37", i, n); end
            end
            checks++; if (bus.out_addr !== 4'(i % 16)) begin failures++;
                $display("FAIL b2b_addr tile=%0d got=%0d exp=%0d", i, bus.out_addr, i % 16); end
            if (i == 16) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        start_tile(); wait_valid(n);
        checks++; if (bus.out_addr !== 4'd1) begin failures++; $display("FAIL addr_after_wrap got=%0d exp=1", bus.out_addr); end
        bus.addr_clr = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_addr !== 4'd0 || bus.out_valid !== 1'b1) begin failures++;
            $display("FAIL addr_clr_emit got addr=%0d valid=%b exp addr=0 valid=1", bus.out_addr, bus.out_valid); end
        start_tile_noop();
    endtask

    task automatic start_tile_noop();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.addr_clr = 1'b0;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_addr !== 4'd0 || bus.out_valid !== 1'b0) begin failures++;
            $display("FAIL addr_clr_hs got addr=%0d valid=%b exp addr=0 valid=0", bus.out_addr, bus.out_valid); end
        bus.out_ready = 1'b1;
    endtask

`ifdef CONV_POOL_AVG_EN
    task automatic test_avg();
        int n;
        ramp_image(); identity_kernels();
        bus.pool_mode = 1'b1;
        start_tile();
        bus.pool_mode = 1'b0;
        wait_valid(n);
        checks++; if (bus.y !== 24'h090909) begin failures++; $display("FAIL avg_y got=%h exp=090909", bus.y); end
        @(negedge clk);
        start_tile();
        bus.pool_mode = 1'b1;
        wait_valid(n);
        checks++; if (bus.y !== 24'h0B0B0B) begin failures++; $display("FAIL max_mode_y got=%h exp=0b0b0b", bus.y); end
        @(negedge clk);
        bus.pool_mode = 1'b0;
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0; bus.image = '0; bus.kernels = '0; bus.shift = '0;
        bus.addr_clr = 1'b0; bus.out_ready = 1'b1;
`ifdef CONV_POOL_AVG_EN
        bus.pool_mode = 1'b0;
`endif
        img = '0; kern = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_identity();
        test_taps();
        test_saturation();
        test_backpressure();
        test_async_reset();
        test_address();
`ifdef CONV_POOL_AVG_EN
        test_avg();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
